axil_bridge_gen2: RTL and testbench
===================================

Name: axil_bridge_gen2

Overview:
Parametrised successor of the invalid/outvalid-to-AXI4-Lite bridge. Converts a single-beat command (C_in_valid pulse with r/w, word address, data, byte strobes) into one AXI4-Lite read or write transaction. Returns the data and response through a one-cycle C_out_valid pulse.
- Generalises data width, address width and base address.
- Adds concurrent AW/W issue, byte strobes, response-code return and a busy indication.
- Sits between the controller FSM and the AXI4-Lite DRAM/slave model.

Parameters:
DATA_W, 32, AXI data width; multiple of 8, at least 32.
CADDR_W, 8, command word-address width.
AXI_ADDR_W, 17, AXI address width; must be at least CADDR_W+log2(DATA_W/8).
BASE_ADDR, 17'h10000, OR-ed into every AXI address; low CADDR_W+log2(DATA_W/8) bits must be zero.
TIMEOUT_CYC, 255, watchdog limit; used only when the optional feature is compiled in.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
C_in_valid  in  1  command strobe, one cycle
C_r_wb  in  1  1=read, 0=write
C_addr  in  CADDR_W  word address
C_data_w  in  DATA_W  write data
C_strb  in  DATA_W/8  write byte enables
C_busy  out  1  bridge not idle
C_out_valid  out  1  completion pulse
C_data_r  out  DATA_W  read data
C_resp  out  2  AXI response of the completed transaction
AR_VALID/AR_READY  out/in  1  read-address handshake
AR_ADDR  out  AXI_ADDR_W  read address
R_VALID/R_READY  in/out  1  read-data handshake
R_DATA  in  DATA_W  read data
R_RESP  in  2  read response
AW_VALID/AW_READY  out/in  1  write-address handshake
AW_ADDR  out  AXI_ADDR_W  write address
W_VALID/W_READY  out/in  1  write-data handshake
W_DATA  out  DATA_W  write data
W_STRB  out  DATA_W/8  write strobes
B_VALID/B_READY  in/out  1  write-response handshake
B_RESP  in  2  write response

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE.
- States: IDLE, AR, R, WR, B.
- IDLE:
  - C_in_valid=1 and C_r_wb=1 -> AR. Next cycle AR_VALID=1 and AR_ADDR=BASE_ADDR|(C_addr<<log2(DATA_W/8)).
  - C_in_valid=1 and C_r_wb=0 -> WR. Next cycle AW_VALID=1 and W_VALID=1, both together; AW_ADDR formed as for AR_ADDR; W_DATA=C_data_w; W_STRB=C_strb.
- AR: AR_VALID stays high until AR_VALID&AR_READY; it is low in the cycle after the handshake. Handshake -> R.
- R:
  - R_READY=1 for the whole R state.
  - On R_VALID&R_READY: latch C_data_r=R_DATA and C_resp=R_RESP, then -> IDLE.
- WR:
  - AW and W complete independently; each VALID drops the cycle after its own handshake.
  - Same-cycle handshakes are allowed.
  - Go to B once both have completed.
- B:
  - B_READY=1 for the whole B state.
  - On B_VALID&B_READY: latch C_resp=B_RESP, then -> IDLE. C_data_r is unchanged by writes.
- C_out_valid: exactly one-cycle pulse, registered in the cycle after the final handshake. C_data_r and C_resp are valid in that cycle and hold until the next completion.
- Latency: minimum 3 cycles from C_in_valid to C_out_valid for a read with READY/VALID already high.
- C_busy: 1 in every state other than IDLE. C_in_valid while C_busy=1 is ignored; no queueing.
- Address/data stability: AXI address, data and strobe outputs hold while their VALID is high; they change only on IDLE exit.
- READY before VALID: a READY seen before the matching VALID is legal and must not cause a handshake.
- Reset mid-transaction: immediate IDLE, all VALID/READY outputs forced 0, no C_out_valid.

Optional Feature:
Macro AXIL_BRIDGE_TIMEOUT_EN.
- Compiled in:
  - Counter clears on IDLE exit and on every AXI handshake; increments in any non-IDLE state.
  - When it reaches TIMEOUT_CYC, all VALID/READY outputs are dropped, state -> IDLE, C_out_valid pulses with C_resp=2'b10 (SLVERR) and C_data_r=0.
- Compiled out: no counter; the bridge waits indefinitely.

Decomposition:
- Package axil_bridge_pkg:
  - State enum AXIL_STATE: IDLE, AR, R, WR, B.
  - Response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Address-formation function.
- Sub-module axil_bridge_wdog: counter with clear/enable/expire, instantiated only under the macro.

Test Plan:
- Read, C_addr=8'h05, slave AR_READY and R_VALID immediate, R_DATA=32'hDEADBEEF, R_RESP=0 -> AR_ADDR=17'h10014; C_out_valid pulse 3 cycles after C_in_valid; C_data_r=32'hDEADBEEF, C_resp=0.
- Write, C_addr=8'hFF, C_data_w=32'h12345678, C_strb=4'b0011; AW_READY delayed 4 cycles, W_READY immediate -> W_VALID drops first, AW_VALID held 4 cycles; AW_ADDR=17'h103FC, W_STRB=4'b0011; a single C_out_valid after the B handshake.
- Write with B_RESP=2'b10 -> C_resp=2'b10; C_data_r keeps the value from the previous read.
- Second C_in_valid issued while C_busy=1 -> ignored; no extra AXI VALID and exactly one C_out_valid.
- rst_n asserted while AW_VALID=1 -> all outputs 0 asynchronously; a subsequent read completes normally.
- With AXIL_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=16, R_VALID never asserted -> C_out_valid pulses with C_resp=2'b10 and C_data_r=0; R_READY=0 and C_busy=0 afterwards.

Source files
------------

// File: rtl/axil_bridge_pkg.sv
// axil_bridge_pkg: shared state encoding, AXI response codes and address formation for axil_bridge_gen2
package axil_bridge_pkg;
  typedef enum logic [2:0] {IDLE, AR, R, WR, B} AXIL_STATE;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic logic [63:0] axil_addr(input logic [63:0] waddr, input int unsigned shift, input logic [63:0] base);
    return base | (waddr << shift);
  endfunction
endpackage

// File: rtl/axil_bridge_wdog.sv
// axil_bridge_wdog: stall watchdog, instantiated only when AXIL_BRIDGE_TIMEOUT_EN is defined
module axil_bridge_wdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q;
  assign expire_o = cnt_q == W'(LIMIT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && !expire_o) cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/axil_bridge_gen2.sv
// axil_bridge_gen2: single-beat command to AXI4-Lite read/write bridge
// AXIL_BRIDGE_TIMEOUT_EN compiles in a watchdog that aborts stalled transactions with SLVERR
module axil_bridge_gen2
  import axil_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CADDR_W = 8,
  parameter int unsigned AXI_ADDR_W = 17,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 17'h10000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  C_in_valid,
  input  logic                  C_r_wb,
  input  logic [CADDR_W-1:0]    C_addr,
  input  logic [DATA_W-1:0]     C_data_w,
  input  logic [DATA_W/8-1:0]   C_strb,
  output logic                  C_busy,
  output logic                  C_out_valid,
  output logic [DATA_W-1:0]     C_data_r,
  output logic [1:0]            C_resp,
  output logic                  AR_VALID,
  input  logic                  AR_READY,
  output logic [AXI_ADDR_W-1:0] AR_ADDR,
  input  logic                  R_VALID,
  output logic                  R_READY,
  input  logic [DATA_W-1:0]     R_DATA,
  input  logic [1:0]            R_RESP,
  output logic                  AW_VALID,
  input  logic                  AW_READY,
  output logic [AXI_ADDR_W-1:0] AW_ADDR,
  output logic                  W_VALID,
  input  logic                  W_READY,
  output logic [DATA_W-1:0]     W_DATA,
  output logic [DATA_W/8-1:0]   W_STRB,
  input  logic                  B_VALID,
  output logic                  B_READY,
  input  logic [1:0]            B_RESP
);
  localparam int unsigned SHIFT = $clog2(DATA_W / 8);
  if (DATA_W % 8 != 0 || DATA_W < 32) $error("DATA_W must be a multiple of 8 and at least 32");
  if (AXI_ADDR_W < CADDR_W + SHIFT) $error("AXI_ADDR_W too narrow for CADDR_W");
  if (BASE_ADDR[CADDR_W+SHIFT-1:0] != '0) $error("BASE_ADDR overlaps the word-address bits");
  if (TIMEOUT_CYC == 0) $error("TIMEOUT_CYC must be non-zero");
  AXIL_STATE state_q;
  logic ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q, out_valid_q;
  logic [AXI_ADDR_W-1:0] ar_addr_q, aw_addr_q, addr_w;
  logic [DATA_W-1:0] w_data_q, data_r_q;
  logic [DATA_W/8-1:0] w_strb_q;
  logic [1:0] resp_q;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, to;
  assign addr_w = AXI_ADDR_W'(axil_addr(64'(C_addr), SHIFT, 64'(BASE_ADDR)));
  assign ar_hs = ar_valid_q & AR_READY;
  assign r_hs = r_ready_q & R_VALID;
  assign aw_hs = aw_valid_q & AW_READY;
  assign w_hs = w_valid_q & W_READY;
  assign b_hs = b_ready_q & B_VALID;
`ifdef AXIL_BRIDGE_TIMEOUT_EN
  axil_bridge_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q == IDLE || ar_hs || r_hs || aw_hs || w_hs || b_hs),
    .en_i     (state_q != IDLE),
    .expire_o (to)
  );
`else
  assign to = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ar_valid_q <= 1'b0;
      r_ready_q <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q <= 1'b0;
      b_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      ar_addr_q <= '0;
      aw_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      data_r_q <= '0;
      resp_q <= RESP_OKAY;
    end else begin
      out_valid_q <= 1'b0;
      if (to) begin
        state_q <= IDLE;
        ar_valid_q <= 1'b0;
        r_ready_q <= 1'b0;
        aw_valid_q <= 1'b0;
        w_valid_q <= 1'b0;
        b_ready_q <= 1'b0;
        out_valid_q <= 1'b1;
        data_r_q <= '0;
        resp_q <= RESP_SLVERR;
      end else case (state_q)
        IDLE: if (C_in_valid) begin
          if (C_r_wb) begin
            ar_addr_q <= addr_w;
            ar_valid_q <= 1'b1;
            state_q <= AR;
          end else begin
            aw_addr_q <= addr_w;
            w_data_q <= C_data_w;
            w_strb_q <= C_strb;
            aw_valid_q <= 1'b1;
            w_valid_q <= 1'b1;
            state_q <= WR;
          end
        end
        AR: if (ar_hs) begin
          ar_valid_q <= 1'b0;
          r_ready_q <= 1'b1;
          state_q <= R;
        end
        R: if (r_hs) begin
          r_ready_q <= 1'b0;
          data_r_q <= R_DATA;
          resp_q <= R_RESP;
          out_valid_q <= 1'b1;
          state_q <= IDLE;
        end
        WR: begin
          if (aw_hs) aw_valid_q <= 1'b0;
          if (w_hs) w_valid_q <= 1'b0;
          // both channels done once each has handshaken now or earlier
          if ((aw_hs || !aw_valid_q) && (w_hs || !w_valid_q)) begin
            b_ready_q <= 1'b1;
            state_q <= B;
          end
        end
        B: if (b_hs) begin
          b_ready_q <= 1'b0;
          resp_q <= B_RESP;
          out_valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign C_busy = state_q != IDLE;
  assign C_out_valid = out_valid_q;
  assign C_data_r = data_r_q;
  assign C_resp = resp_q;
  assign AR_VALID = ar_valid_q;
  assign AR_ADDR = ar_addr_q;
  assign R_READY = r_ready_q;
  assign AW_VALID = aw_valid_q;
  assign AW_ADDR = aw_addr_q;
  assign W_VALID = w_valid_q;
  assign W_DATA = w_data_q;
  assign W_STRB = w_strb_q;
  assign B_READY = b_ready_q;
endmodule

// File: tb/tb_axil_bridge_gen2.sv
// tb_axil_bridge_gen2: table-driven check of axil_bridge_gen2 against a delay-configurable AXI4-Lite slave
module tb_axil_bridge_gen2;
  logic clk, rst_n;
  logic C_in_valid, C_r_wb, C_busy, C_out_valid;
  logic [7:0] C_addr;
  logic [31:0] C_data_w, C_data_r;
  logic [3:0] C_strb;
  logic [1:0] C_resp;
  logic AR_VALID, AR_READY, R_VALID, R_READY, AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic [16:0] AR_ADDR, AW_ADDR;
  logic [31:0] R_DATA, W_DATA;
  logic [3:0] W_STRB;
  logic [1:0] R_RESP, B_RESP;

  axil_bridge_gen2 #(.DATA_W(32), .CADDR_W(8), .AXI_ADDR_W(17), .BASE_ADDR(17'h10000), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr),
    .C_data_w(C_data_w), .C_strb(C_strb), .C_busy(C_busy), .C_out_valid(C_out_valid),
    .C_data_r(C_data_r), .C_resp(C_resp), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
    .AR_ADDR(AR_ADDR), .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .W_VALID(W_VALID),
    .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB), .B_VALID(B_VALID), .B_READY(B_READY),
    .B_RESP(B_RESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r_wb; logic [7:0] addr; logic [31:0] wdata; logic [3:0] strb;
    logic [31:0] rdata; logic [1:0] sresp;
    int ar_hold, aw_hold, w_hold, sdly; logic inj;
    logic [16:0] exp_addr; logic [31:0] exp_data; logic [1:0] exp_resp; int exp_lat;
  } vec_t;

  int total = 0, bad = 0;
  int ar_hold = 1, aw_hold = 1, w_hold = 1, sdly = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0] s_resp = '0;
  int ar_n, aw_n, w_n, r_n, b_n;
  logic r_pend, b_pend, aw_got, w_got, aw_hs, w_hs;

  // slave: READY after VALID held for *_hold cycles (hold 1 = READY always high, even before VALID)
  assign AR_READY = ar_hold <= 1 || (AR_VALID && ar_n >= ar_hold - 1);
  assign AW_READY = aw_hold <= 1 || (AW_VALID && aw_n >= aw_hold - 1);
  assign W_READY = w_hold <= 1 || (W_VALID && w_n >= w_hold - 1);
  assign R_DATA = s_rdata;
  assign R_RESP = s_resp;
  assign B_RESP = s_resp;
  assign aw_hs = AW_VALID && AW_READY;
  assign w_hs = W_VALID && W_READY;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      R_VALID <= 0; B_VALID <= 0; r_pend <= 0; b_pend <= 0; aw_got <= 0; w_got <= 0;
      ar_n <= 0; aw_n <= 0; w_n <= 0; r_n <= 0; b_n <= 0;
    end else begin
      ar_n <= (AR_VALID && !AR_READY) ? ar_n + 1 : 0;
      aw_n <= (AW_VALID && !AW_READY) ? aw_n + 1 : 0;
      w_n <= (W_VALID && !W_READY) ? w_n + 1 : 0;
      if (R_VALID && R_READY) R_VALID <= 0;
      if (AR_VALID && AR_READY) begin
        if (sdly == 0) R_VALID <= 1; else begin r_pend <= 1; r_n <= 1; end
      end else if (r_pend) begin
        if (r_n >= sdly) begin R_VALID <= 1; r_pend <= 0; end else r_n <= r_n + 1;
      end
      if (aw_hs) aw_got <= 1;
      if (w_hs) w_got <= 1;
      if (B_VALID && B_READY) B_VALID <= 0;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        aw_got <= 0; w_got <= 0;
        if (sdly == 0) B_VALID <= 1; else begin b_pend <= 1; b_n <= 1; end
      end else if (b_pend) begin
        if (b_n >= sdly) begin B_VALID <= 1; b_pend <= 0; end else b_n <= b_n + 1;
      end
    end

  int ar_cyc = 0, aw_cyc = 0, w_cyc = 0, ov_cnt = 0, unstable = 0;
  logic [16:0] ar_addr_s = '0, aw_addr_s = '0, p_ar = '0, p_aw = '0;
  logic [31:0] wdata_s = '0;
  logic [3:0] wstrb_s = '0;
  logic [35:0] p_w = '0;
  logic pv_ar = 0, pv_aw = 0, pv_w = 0;
  always @(negedge clk) begin
    if (AR_VALID) begin ar_cyc++; ar_addr_s = AR_ADDR; end
    if (AW_VALID) begin aw_cyc++; aw_addr_s = AW_ADDR; end
    if (W_VALID) begin w_cyc++; wdata_s = W_DATA; wstrb_s = W_STRB; end
    if (C_out_valid) ov_cnt++;
    if ((AR_VALID && pv_ar && AR_ADDR != p_ar) || (AW_VALID && pv_aw && AW_ADDR != p_aw) ||
        (W_VALID && pv_w && {W_DATA, W_STRB} != p_w)) unstable++;
    pv_ar = AR_VALID; pv_aw = AW_VALID; pv_w = W_VALID;
    p_ar = AR_ADDR; p_aw = AW_ADDR; p_w = {W_DATA, W_STRB};
  end

  logic any_out;
  assign any_out = |{C_busy, C_out_valid, C_data_r, C_resp, AR_VALID, AR_ADDR, R_READY,
                     AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int id);
    int lat, ov0, ar0, aw0, w0;
    ar_hold = v.ar_hold; aw_hold = v.aw_hold; w_hold = v.w_hold; sdly = v.sdly;
    s_rdata = v.rdata; s_resp = v.sresp;
    @(negedge clk);
    ov0 = ov_cnt; ar0 = ar_cyc; aw0 = aw_cyc; w0 = w_cyc;
    C_in_valid = 1; C_r_wb = v.r_wb; C_addr = v.addr; C_data_w = v.wdata; C_strb = v.strb;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      C_in_valid = v.inj && lat == 1;
      if (lat == 1) begin
        chk($sformatf("v%0d busy", id), C_busy, 1);
        C_r_wb = !v.r_wb; C_addr = 8'hAA; C_data_w = 32'hFFFFFFFF; C_strb = 4'hF;
      end
    end while (!C_out_valid && lat < 200);
    C_in_valid = 0;
    chk($sformatf("v%0d latency", id), lat, v.exp_lat);
    chk($sformatf("v%0d data_r", id), C_data_r, v.exp_data);
    chk($sformatf("v%0d resp", id), C_resp, v.exp_resp);
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d pulses", id), ov_cnt - ov0, 1);
    chk($sformatf("v%0d idle", id), {C_busy, AR_VALID, R_READY, AW_VALID, W_VALID, B_READY}, 0);
    if (v.r_wb) begin
      chk($sformatf("v%0d ar_addr", id), ar_addr_s, v.exp_addr);
      chk($sformatf("v%0d ar_cycles", id), ar_cyc - ar0, v.ar_hold);
      chk($sformatf("v%0d no_aw", id), aw_cyc - aw0, 0);
    end else begin
      chk($sformatf("v%0d aw_addr", id), aw_addr_s, v.exp_addr);
      chk($sformatf("v%0d w_data", id), wdata_s, v.wdata);
      chk($sformatf("v%0d w_strb", id), wstrb_s, v.strb);
      chk($sformatf("v%0d aw_cycles", id), aw_cyc - aw0, v.aw_hold);
      chk($sformatf("v%0d w_cycles", id), w_cyc - w0, v.w_hold);
      chk($sformatf("v%0d no_ar", id), ar_cyc - ar0, 0);
    end
  endtask

  initial begin
    vec_t vt[8];
    int ov0;
    rst_n = 0; C_in_valid = 0; C_r_wb = 0; C_addr = 0; C_data_w = 0; C_strb = 0;
    //        r_wb  addr   wdata         strb  rdata         resp  ar aw w dly inj exp_addr    exp_data      resp  lat
    vt[0] = '{1'b1, 8'h05, 32'h0,        4'h0, 32'hDEADBEEF, 2'd0, 1, 1, 1, 0, 1'b0, 17'h10014, 32'hDEADBEEF, 2'd0, 3};
    vt[1] = '{1'b0, 8'hFF, 32'h12345678, 4'h3, 32'h0,        2'd0, 1, 4, 1, 0, 1'b0, 17'h103FC, 32'hDEADBEEF, 2'd0, 6};
    vt[2] = '{1'b0, 8'h00, 32'hA5A5A5A5, 4'hF, 32'h0,        2'd2, 1, 1, 3, 2, 1'b0, 17'h10000, 32'hDEADBEEF, 2'd2, 7};
    vt[3] = '{1'b1, 8'h80, 32'h0,        4'h0, 32'hCAFEF00D, 2'd1, 3, 1, 1, 2, 1'b0, 17'h10200, 32'hCAFEF00D, 2'd1, 7};
    vt[4] = '{1'b0, 8'h3C, 32'h0BADC0DE, 4'h8, 32'h0,        2'd3, 1, 2, 2, 0, 1'b0, 17'h100F0, 32'hCAFEF00D, 2'd3, 4};
    vt[5] = '{1'b1, 8'h01, 32'h0,        4'h0, 32'h13579BDF, 2'd2, 2, 1, 1, 1, 1'b0, 17'h10004, 32'h13579BDF, 2'd2, 5};
    vt[6] = '{1'b0, 8'h10, 32'h11112222, 4'h5, 32'h0,        2'd0, 1, 3, 3, 1, 1'b1, 17'h10040, 32'h13579BDF, 2'd0, 6};
    vt[7] = '{1'b1, 8'h7F, 32'h0,        4'h0, 32'h80000001, 2'd0, 1, 1, 1, 0, 1'b1, 17'h101FC, 32'h80000001, 2'd0, 3};
    repeat (3) @(negedge clk);
    chk("reset outputs", any_out, 0);
    rst_n = 1;
    foreach (vt[i]) run(vt[i], i);
    aw_hold = 100; w_hold = 100;
    @(negedge clk);
    C_in_valid = 1; C_r_wb = 0; C_addr = 8'h22; C_data_w = 32'h77778888; C_strb = 4'hF;
    @(negedge clk);
    C_in_valid = 0;
    @(negedge clk);
    chk("rst pre aw_valid", AW_VALID, 1);
    ov0 = ov_cnt;
    #2 rst_n = 0;
    #1 chk("rst async clear", any_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("rst no pulse", ov_cnt - ov0, 0);
    chk("rst stays idle", any_out, 0);
    run(vt[0], 8);
`ifdef AXIL_BRIDGE_TIMEOUT_EN
    run('{1'b1, 8'h33, 32'h0, 4'h0, 32'h55, 2'd0, 1, 1, 1, 1000, 1'b0, 17'h100CC, 32'h0, 2'd2, 19}, 9);
`endif
    chk("addr/data stable", unstable, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
